// File: rtl/dsp_add_issue_pkg.sv
// rtl/dsp_add_issue_pkg.sv - shared constants and width helpers for the dsp_add issue front-end
package dsp_add_issue_pkg;

  // Pipeline depth of the dsp_add primitive this block is normally paired with.
  localparam int DSP_ADD_LATENCY = 2;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a pointer that indexes 0..depth-1.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dsp_add.sv
// rtl/dsp_add.sv - fixed-latency, non-stallable WIDTH-bit adder primitive
module dsp_add #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] stage_q [LATENCY];

  assign sum = a_i + b_i;

  // Free-running delay line: the sum of a/b appears on y LATENCY cycles later.
  always_ff @(posedge clock) begin
    stage_q[0] <= sum;
    for (int i = 1; i < LATENCY; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign y_o = stage_q[LATENCY-1];

endmodule

// File: rtl/dsp_result_fifo.sv
// rtl/dsp_result_fifo.sv - circular result buffer with push/pop/count/empty
module dsp_result_fifo
  import dsp_add_issue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              push_data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              pop_data_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o,
  output logic                          empty_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; a simultaneous push and pop keeps count.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = ptr_next(wr_q);
    if (do_pop)  rd_d = ptr_next(rd_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries are only visible once counted.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_q];
  assign count_o    = count_q;

endmodule

// File: rtl/dsp_add_issue.sv
// rtl/dsp_add_issue.sv - valid/ready stream front-end for the fixed-latency dsp_add primitive
module dsp_add_issue
  import dsp_add_issue_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = DSP_ADD_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
);

  localparam int          CW         = cnt_width(DEPTH);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [LATENCY:0] vpipe_q, vpipe_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [CW:0]      credit_used;
  logic             fire_in;
  logic             push;
  logic             pop;

  // Every accepted pair owns one FIFO slot from issue until it is popped, so the
  // adder can never deliver a result the buffer has no room for.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready    = reset && (credit_used < CREDIT_MAX);
  assign fire_in     = in_valid && in_ready;
  assign push        = vpipe_q[LATENCY];
  assign pop         = out_valid && out_ready;

  // Operand capture, valid-tag shift and in-flight credit next-state.
  always_comb begin
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    vpipe_d    = {vpipe_q[LATENCY-1:0], fire_in};
    inflight_d = inflight_q;
    if (fire_in) begin
      add_a_d = in_a;
      add_b_d = in_b;
    end
    case ({fire_in, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Issue-side state; clearing vpipe on reset makes late add_y values harmless.
  always_ff @(posedge clock) begin
    if (!reset) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      vpipe_q    <= '0;
      inflight_q <= '0;
    end else begin
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      vpipe_q    <= vpipe_d;
      inflight_q <= inflight_d;
    end
  end

  dsp_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (add_y),
    .pop_i       (pop),
    .pop_data_o  (out_y),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_dsp_add_issue.sv
// tb/tb_dsp_add_issue.sv - self-checking bench for dsp_add_issue with a dsp_add instance
module tb_dsp_add_issue;

  localparam int WIDTH = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a      = '0;
  logic [WIDTH-1:0] in_b      = '0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_y;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  dsp_add_issue #(
    .WIDTH   (WIDTH),
    .LATENCY (LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  dsp_add #(
    .WIDTH   (WIDTH),
    .LATENCY (LAT)
  ) u_add (
    .clock (clock),
    .a_i   (add_a),
    .b_i   (add_b),
    .y_o   (add_y)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: every accepted pair is outstanding until popped; its sum
  // becomes visible LAT+1 edges after the accepting edge; results leave in order.
  typedef struct {
    logic [WIDTH-1:0] y;
    int               rdy;
  } exp_t;
  exp_t mq[$];

  always @(negedge clock) begin
    bit   exp_valid;
    bit   exp_ready;
    exp_t e;
    exp_valid = (mq.size() != 0) && (cyc >= mq[0].rdy);
    exp_ready = reset && (mq.size() < DEPTH);
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL mon_out_valid cyc=%0d got %b want %b", cyc, out_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (out_y !== mq[0].y) begin
        errors++;
        $display("FAIL mon_out_y cyc=%0d got %h want %h", cyc, out_y, mq[0].y);
      end
    end
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL mon_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_ready);
    end
    checks++;
    if (mq.size() > DEPTH) begin
      errors++;
      $display("FAIL mon_credit cyc=%0d outstanding %0d limit %0d", cyc, mq.size(), DEPTH);
    end
    if (!reset) begin
      mq.delete();
    end else begin
      if (exp_valid && out_ready) mq.delete(0);
      if (in_valid && in_ready) begin
        e.y   = WIDTH'(in_a + in_b);
        e.rdy = cyc + 2 + LAT;
        mq.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++;
    if (add_a !== '0 || add_b !== '0) begin
      errors++; $display("FAIL rst_add_ab got %h/%h want 00/00", add_a, add_b);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int first_k = -1;
    int drops   = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'hFF;
    in_b      = 8'h10;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", in_ready); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clock);
      if (in_ready !== 1'b1) drops++;
      if (out_valid === 1'b1 && first_k < 0) begin
        first_k = k;
        checks++;
        if (out_y !== 8'h0F) begin errors++; $display("FAIL single_y got %h want 0f", out_y); end
      end
      @(posedge clock); #1;
    end
    checks++;
    if (first_k != LAT + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", first_k, LAT + 2); end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL single_in_ready drops %0d want 0", drops); end
  endtask

  task automatic test_streaming();
    int sent = 0;
    int got  = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 60 && got < 16; t++) begin
      in_valid = (sent < 16);
      in_a     = WIDTH'(sent);
      in_b     = WIDTH'(2 * sent);
      @(negedge clock);
      if (out_valid === 1'b1) begin
        checks++;
        if (out_y !== WIDTH'(3 * got)) begin
          errors++; $display("FAIL stream_y idx %0d got %h want %h", got, out_y, WIDTH'(3 * got));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16 || sent != 16) begin
      errors++; $display("FAIL stream_count got %0d sent %0d want 16/16", got, sent);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] pa[6];
    logic [WIDTH-1:0] pb[6];
    logic [WIDTH-1:0] first_y;
    int acc      = 0;
    int got      = 0;
    int unstable = 0;
    bit seen     = 0;
    for (int i = 0; i < 6; i++) begin
      pa[i] = WIDTH'($urandom);
      pb[i] = WIDTH'($urandom);
    end
    out_ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      in_valid = (acc < 6);
      if (acc < 6) begin in_a = pa[acc]; in_b = pb[acc]; end
      @(negedge clock);
      if (out_valid === 1'b1) begin
        if (!seen) begin first_y = out_y; seen = 1; end
        else if (out_y !== first_y) unstable++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++;
    if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    checks++;
    if (!seen || first_y !== WIDTH'(pa[0] + pb[0])) begin
      errors++; $display("FAIL bp_head got %h want %h", first_y, WIDTH'(pa[0] + pb[0]));
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_hold changes %0d want 0", unstable); end
    if (in_valid && in_ready) acc++;
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 30 && (got < 6 || acc < 6); t++) begin
      in_valid = (acc < 6);
      if (acc < 6) begin in_a = pa[acc]; in_b = pb[acc]; end
      @(negedge clock);
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 6 || out_y !== WIDTH'(pa[got] + pb[got])) begin
          errors++; $display("FAIL bp_drain idx %0d got %h", got, out_y);
        end
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6 || acc != 6) begin errors++; $display("FAIL bp_total got %0d acc %0d want 6/6", got, acc); end
    idle(2);
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] wa[2];
    logic [WIDTH-1:0] wb[2];
    logic [WIDTH-1:0] wy[2];
    int sent = 0;
    int got  = 0;
    wa[0] = 8'h80; wb[0] = 8'h80; wy[0] = 8'h00;
    wa[1] = 8'h7F; wb[1] = 8'h01; wy[1] = 8'h80;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && got < 2; t++) begin
      in_valid = (sent < 2);
      if (sent < 2) begin in_a = wa[sent]; in_b = wb[sent]; end
      @(negedge clock);
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 2 || out_y !== wy[got]) begin errors++; $display("FAIL wrap_y idx %0d got %h", got, out_y); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", got); end
    idle(2);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] ea;
    int sent = 0;
    int got  = 0;
    bit fired;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    for (int t = 0; t < 3000 && got < 60; t++) begin
      in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
      out_ready = (((t / 10) % 3) == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra got %h want none", out_y);
        end else begin
          ea = exp_q.pop_front();
          if (out_y !== ea) begin errors++; $display("FAIL rand_y idx %0d got %h want %h", got, out_y, ea); end
        end
        got++;
      end
      fired = in_valid && in_ready;
      if (fired) begin
        exp_q.push_back(WIDTH'(in_a + in_b));
        sent++;
      end
      @(posedge clock); #1;
      if (fired) begin
        in_a = WIDTH'($urandom);
        in_b = WIDTH'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 60 || sent != 60) begin errors++; $display("FAIL rand_count got %0d sent %0d want 60/60", got, sent); end
    idle(2);
  endtask

  task automatic test_mid_reset();
    int acc    = 0;
    int outs   = 0;
    int sent   = 0;
    int stale  = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 10 && acc < 4; t++) begin
      in_valid = 1'b1;
      in_a     = WIDTH'($urandom);
      in_b     = WIDTH'($urandom);
      @(negedge clock);
      if (in_ready) acc++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid got %b want 1", out_valid); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready_low got %b want 0", in_ready); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mrst_after got valid %b ready %b want 0 0", out_valid, in_ready);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) stale++;
      @(posedge clock); #1;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mrst_stale cycles %0d want 0", stale); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h01;
    in_b      = 8'h01;
    for (int t = 0; t < 12; t++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        outs++;
        checks++;
        if (out_y !== 8'h02) begin errors++; $display("FAIL mrst_y got %h want 02", out_y); end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
      if (sent != 0) in_valid = 1'b0;
    end
    checks++;
    if (outs != 1 || sent != 1) begin errors++; $display("FAIL mrst_outs got %0d sent %0d want 1/1", outs, sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
